// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Circular {pc, instr} FIFO between fetch and decode with flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [31:0]               pc_in,
    input  logic [31:0]               instr_in,
    output logic                      in_ready,
    output logic                      stall_pc,
    input  logic                      flush,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [31:0]               pc_out,
    output logic [31:0]               instr_out,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int                  c_ptr_w = $clog2(DEPTH);
    localparam int                  c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]  c_full  = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_empty = '0;

    logic [31:0]         r_pc_mem    [DEPTH];
    logic [31:0]         r_instr_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_push;
    logic                w_pop;

    // A full queue never accepts, even if the head leaves this same cycle.
    assign in_ready  = (r_count != c_full);
    assign stall_pc  = ~in_ready;
    assign out_valid = (r_count != c_empty) && !flush;
    assign count     = r_count;

    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready;

    assign pc_out    = out_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
    assign instr_out = out_valid ? r_instr_mem[r_rd_ptr] : NOP_INSTR;

    // Storage is deliberately not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= pc_in;
            r_instr_mem[r_wr_ptr] <= instr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed scoreboard bench for fetch_queue (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        in_ready;
    logic        stall_pc;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [2:0]  count;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [31:0] sb_pc[$];

    fetch_queue #(.DEPTH(4), .NOP_INSTR(c_nop)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .in_ready  (in_ready),
        .stall_pc  (stall_pc),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .pc_out    (pc_out),
        .instr_out (instr_out),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {8'hA5, pc[23:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        pc_in     = pc;
        instr_in  = instr_of(pc);
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every real pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pops++;
            if (sb_pc.size() == 0) begin
                chk("unexpected_pop_pc", pc_out, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = sb_pc.pop_front();
                chk("pop_pc", pc_out, e);
                chk("pop_instr", instr_out, instr_of(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instr_out", instr_out, c_nop);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_stall_pc", 32'(stall_pc), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // Three pushes, decode stalled
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            sb_pc.push_back(32'(4 * i));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("three_count", 32'(count), 32'd3);
        chk("three_out_valid", 32'(out_valid), 32'd1);
        chk("three_pc_out", pc_out, 32'h0);
        chk("three_instr_out", instr_out, instr_of(32'h0));
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) tick();
        chk("three_drained_count", 32'(count), 32'd0);

        // Fill to full, fifth push rejected, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            sb_pc.push_back(32'(4 * i));
            tick();
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_stall_pc", 32'(stall_pc), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        tick();
        chk("full_reject_count", 32'(count), 32'd4);
        chk("full_reject_head", pc_out, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (4) tick();
        chk("full_drained_count", 32'(count), 32'd0);
        chk("full_drained_valid", 32'(out_valid), 32'd0);

        // Streaming push+pop for 10 cycles, pointers wrap twice
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
            sb_pc.push_back(32'(4 * i));
            tick();
            chk("stream_count", 32'(count), 32'd1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("stream_end_count", 32'(count), 32'd0);

        // Flush with 3 entries held and a push in the flush cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(32'h20 + 4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        sb_pc.delete();
        #1;
        chk("flush_cycle_valid", 32'(out_valid), 32'd0);
        tick();
        drive(1'b1, 32'h80, 1'b0, 1'b0);
        sb_pc.push_back(32'h80);
        #1;
        chk("post_flush_count", 32'(count), 32'd0);
        chk("post_flush_valid", 32'(out_valid), 32'd0);
        chk("post_flush_instr", instr_out, c_nop);
        chk("post_flush_pc", pc_out, 32'h0);
        chk("post_flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("refill_valid", 32'(out_valid), 32'd1);
        chk("refill_pc", pc_out, 32'h80);
        chk("refill_count", 32'(count), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("refill_drained_count", 32'(count), 32'd0);

        // Reset mid-operation with push and pop active
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'(32'h30 + 4 * i), 1'b0, 1'b0);
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 32'h38, 1'b1, 1'b0);
        sb_pc.delete();
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_pc_out", pc_out, 32'h0);

        tick();
        chk("pop_total", 32'(pops), 32'd18);
        chk("sb_leftover", 32'(sb_pc.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, meaning the number of instruction entries buffered, a power of two from 2 to 16.
REQ-002 The block SHALL take parameter NOP_INSTR, default 32'h00000013, meaning the instruction driven to decode when no valid entry exists.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, fetch presents a valid pc_in/instr_in pair this cycle.
REQ-006 The block SHALL have port pc_in, input, 32, PC of the fetched instruction.
REQ-007 The block SHALL have port instr_in, input, 32, fetched instruction word.
REQ-008 The block SHALL have port in_ready, output, 1, queue accepts a push this cycle.
REQ-009 The block SHALL have port stall_pc, output, 1, PC hold request to fetch, equal to ~in_ready.
REQ-010 The block SHALL have port flush, input, 1, branch taken in EX: discard all buffered entries.
REQ-011 The block SHALL have port out_ready, input, 1, decode consumes the head entry this cycle.
REQ-012 The block SHALL have port out_valid, output, 1, head entry valid for decode.
REQ-013 The block SHALL have port pc_out, output, 32, PC of head entry.
REQ-014 The block SHALL have port instr_out, output, 32, instruction of head entry.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1, number of occupied entries.

Function
REQ-016 The block SHALL be a circular FIFO with DEPTH entries of {pc, instr}, a write pointer, a read pointer and an occupancy counter.
REQ-017 A push SHALL occur when in_valid && in_ready && !flush; the entry is written at the write pointer and the pointer advances.
REQ-018 A pop SHALL occur when out_valid && out_ready; the read pointer advances.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 by modulo-DEPTH arithmetic.
REQ-020 count SHALL be incremented on push-only, decremented on pop-only, and unchanged on simultaneous push and pop.
REQ-021 in_ready SHALL equal (count != DEPTH); no pop-through when full, so a full queue rejects a push even if a pop occurs the same cycle.
REQ-022 out_valid SHALL equal (count != 0) && !flush.
REQ-023 There SHALL be no bypass path: an entry pushed in cycle N is first visible on pc_out/instr_out in cycle N+1, for a minimum latency of 1 cycle.
REQ-024 When out_valid is 0, instr_out SHALL be NOP_INSTR and pc_out SHALL be 32'h0.
REQ-025 When out_valid is 1, pc_out and instr_out SHALL be driven combinationally from the entry at the read pointer.
REQ-026 Flush SHALL set count, the read pointer and the write pointer to 0 at the next edge.
REQ-027 Flush SHALL take priority over push and pop in the same cycle, so the flush-cycle push is dropped and no pop is counted.
REQ-028 The first push after a flush SHALL be accepted in the cycle following the flush.
REQ-029 Entries SHALL leave in strict push order; no entry is duplicated or lost except by flush or reset.
REQ-030 A pop while empty and a push while full SHALL be impossible by construction and SHALL leave state unchanged.

Reset
REQ-031 While rst is high at a clock edge, count, the read pointer and the write pointer SHALL be set to 0; storage contents need not be cleared.
REQ-032 In the cycle after reset: out_valid=0, instr_out=NOP_INSTR, pc_out=0, in_ready=1, stall_pc=0, count=0.
REQ-033 Reset SHALL override flush, push and pop in the same cycle; reset mid-operation discards all entries.

Verification
REQ-034 Push pc 0x0/0x4/0x8 with instructions A/B/C and out_ready=0 -> count=3, out_valid=1, pc_out=0x0, instr_out=A.
REQ-035 Fill 4 entries (pc 0x0..0xC) with out_ready=0 -> in_ready=0, stall_pc=1; a fifth push is dropped; then with out_ready=1 the output sequence is pc 0x0, 0x4, 0x8, 0xC and count returns to 0.
REQ-036 Continuous push and pop for 10 cycles with pc 0x0..0x24 -> pointers wrap twice, count stays at 1 after the first cycle, and every pc emerges in order exactly once.
REQ-037 With 3 entries held, assert flush together with in_valid carrying pc 0x40 -> next cycle count=0, out_valid=0, instr_out=0x00000013; push pc 0x80 the following cycle -> pc 0x80 appears on pc_out one cycle later.
REQ-038 Assert rst with 2 entries queued and push and pop active -> next cycle count=0, out_valid=0, in_ready=1, pc_out=0.
